// File: rtl/filter_settle_sequencer_if.sv
// Bundle of configuration inputs and filter-control outputs for one
// channel's settle sequencer. The master modport is the sequencer side;
// the slave modport is the configuration/filter side that drives the
// channel controls and observes the filter controls.
interface filter_settle_sequencer_if;
  logic       ch_en;
  logic       sample_strobe;
  logic       hold;
  logic [4:0] cfg_k;
  logic       cfg_load;
  logic       filt_reset;
  logic       filt_enable;
  logic [4:0] filt_k;
  logic       filt_valid;
  logic       busy;
  logic [1:0] state;

  modport master (
    input  ch_en, sample_strobe, hold, cfg_k, cfg_load,
    output filt_reset, filt_enable, filt_k, filt_valid, busy, state
  );

  modport slave (
    output ch_en, sample_strobe, hold, cfg_k, cfg_load,
    input  filt_reset, filt_enable, filt_k, filt_valid, busy, state
  );
endinterface

// File: rtl/filter_settle_sequencer.sv
// Per-channel sequencer for one moving-integrator filter: holds the filter
// in reset for a fixed flush, applies the tap depth, then gates sample
// strobes into filter enables and counts enough of them to refill the delay
// line and pipeline before declaring the filter output valid.
module filter_settle_sequencer #(
  parameter int K_DEPTH      = 25,
  parameter int PIPE_LAT     = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  filter_settle_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] flush_cnt_q, flush_cnt_d;
  logic [6:0] settle_cnt_q, settle_cnt_d;
  logic [4:0] pending_k_q, pending_k_d;
  logic [4:0] filt_k_q, filt_k_d;
  logic       filt_reset_q, filt_reset_d;
  logic       filt_enable_q, filt_enable_d;
  logic       filt_valid_q, filt_valid_d;
  logic       busy_q, busy_d;
  logic [6:0] settle_n;

  // Enables needed to refill the delay line (depth filt_k+1) and drain the
  // output pipeline; filt_k is stable while this is sampled at FLUSH exit.
  assign settle_n = 7'(filt_k_q) + 7'(PIPE_LAT + 1);

  // State and registered outputs.
  // NOTE: every register here updates with <= so all of them see the
  // pre-edge values computed by the combinational block, independent of
  // statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      flush_cnt_q   <= '0;
      settle_cnt_q  <= '0;
      pending_k_q   <= 5'(K_DEPTH);
      filt_k_q      <= 5'(K_DEPTH);
      filt_reset_q  <= 1'b1;
      filt_enable_q <= 1'b0;
      filt_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      pending_k_q   <= pending_k_d;
      filt_k_q      <= filt_k_d;
      filt_reset_q  <= filt_reset_d;
      filt_enable_q <= filt_enable_d;
      filt_valid_q  <= filt_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and next-output logic; priority is ch_en, then cfg_load,
  // then normal progression.
  always_comb begin
    // NOTE: every target gets a default before any branch so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    pending_k_d   = bus.cfg_load ? bus.cfg_k : pending_k_q;
    filt_k_d      = filt_k_q;
    filt_reset_d  = filt_reset_q;
    filt_enable_d = 1'b0;
    filt_valid_d  = filt_valid_q;

    if (!bus.ch_en) begin
      state_d      = IDLE;
      flush_cnt_d  = '0;
      settle_cnt_d = '0;
      filt_reset_d = 1'b1;
      filt_valid_d = 1'b0;
      if (bus.cfg_load) begin
        filt_k_d = bus.cfg_k;
      end
    end else if (bus.cfg_load) begin
      // New depth: restart the flush; filt_k moves on the same edge that
      // raises filt_reset, so the filter never sees a depth change live.
      state_d      = FLUSH;
      flush_cnt_d  = 8'(FLUSH_CYCLES);
      filt_reset_d = 1'b1;
      filt_valid_d = 1'b0;
      filt_k_d     = bus.cfg_k;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = FLUSH;
          flush_cnt_d  = 8'(FLUSH_CYCLES);
          filt_reset_d = 1'b1;
          filt_valid_d = 1'b0;
          filt_k_d     = pending_k_q;
        end
        FLUSH: begin
          filt_reset_d = 1'b1;
          if (flush_cnt_q == 8'd1) begin
            state_d      = SETTLE;
            flush_cnt_d  = '0;
            settle_cnt_d = settle_n;
            filt_reset_d = 1'b0;
          end else begin
            flush_cnt_d = flush_cnt_q - 8'd1;
          end
        end
        SETTLE: begin
          filt_reset_d  = 1'b0;
          filt_enable_d = bus.sample_strobe & ~bus.hold;
          if (filt_enable_d) begin
            settle_cnt_d = settle_cnt_q - 7'd1;
            if (settle_cnt_q == 7'd1) begin
              state_d      = RUN;
              filt_valid_d = 1'b1;
            end
          end
        end
        RUN: begin
          filt_reset_d  = 1'b0;
          filt_enable_d = bus.sample_strobe & ~bus.hold;
          filt_valid_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == FLUSH) || (state_d == SETTLE);
  end

  assign bus.state       = state_q;
  assign bus.filt_reset  = filt_reset_q;
  assign bus.filt_enable = filt_enable_q;
  assign bus.filt_k      = filt_k_q;
  assign bus.filt_valid  = filt_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/filter_settle_sequencer.md
Name: filter_settle_sequencer

Overview:
Per-channel controller that sequences one moving-integrator filter instance in the self-trigger chain. It holds the filter in reset and flushes it, then applies the tap-depth configuration. It drives the filter's enable from the sample strobe, counts the enabled samples needed to refill the delay line and pipeline, and asserts filt_valid so downstream trigger logic ignores settling transients. It sits between channel configuration registers and the filter's reset/enable/depth inputs.

Parameters:
K_DEPTH, 25, tap depth after reset (0..31).
PIPE_LAT, 4, filter output latency in enabled samples.
FLUSH_CYCLES, 4, clocks filt_reset is held on each flush (1..255).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
ch_en  in  1  channel enable (level).
sample_strobe  in  1  new input sample this cycle.
hold  in  1  freeze filter: no enables, counters frozen.
cfg_k  in  5  requested tap depth.
cfg_load  in  1  one-cycle pulse; apply cfg_k.
filt_reset  out  1  active-high reset to filter.
filt_enable  out  1  enable to filter.
filt_k  out  5  tap depth to filter SRL address.
filt_valid  out  1  filter output is settled.
busy  out  1  high in FLUSH or SETTLE.
state  out  2  IDLE=0, FLUSH=1, SETTLE=2, RUN=3.

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n); all outputs registered.
- On reset_n low, immediately: state=IDLE, filt_reset=1, filt_enable=0, filt_k=K_DEPTH, filt_valid=0, busy=0, counters=0, pending_k=K_DEPTH.
- SETTLE_N = filt_k + 1 + PIPE_LAT, computed at FLUSH exit in 7 bits, no saturation needed (max 36 for defaults).
- IDLE: filt_reset=1, filt_enable=0. If ch_en=1, go to FLUSH and load flush_cnt=FLUSH_CYCLES.
- FLUSH: filt_reset=1, filt_enable=0, busy=1. flush_cnt decrements every clock. On the clock where flush_cnt==1, go to SETTLE, load settle_cnt=SETTLE_N, and drop filt_reset. filt_reset is therefore high for exactly FLUSH_CYCLES clocks after the IDLE->FLUSH edge.
- SETTLE: filt_reset=0, busy=1.
  - filt_enable(next) = sample_strobe & ~hold.
  - Each issued enable decrements settle_cnt.
  - When an enable is issued with settle_cnt==1, go to RUN and set filt_valid=1 on the same edge.
- RUN: filt_enable(next) = sample_strobe & ~hold; filt_valid=1; busy=0.
- hold: in SETTLE or RUN, no enable is issued and settle_cnt is frozen. filt_valid keeps its value. hold is ignored in IDLE and FLUSH.
- cfg_load:
  - Latches cfg_k into pending_k in any state.
  - In IDLE, filt_k=cfg_k on the next clock.
  - In FLUSH, SETTLE or RUN: next state is FLUSH, flush_cnt reloads, filt_valid=0, filt_enable=0, and filt_k=cfg_k on the same edge.
  - filt_k never changes while filt_reset=0.
- Priority, highest first: reset_n, ch_en=0, cfg_load, normal progression.
  - ch_en=0 in any state: next state IDLE, filt_valid=0, filt_enable=0, filt_reset=1. A pending cfg_load in that same cycle still updates filt_k.
  - ch_en rising together with cfg_load in IDLE: go to FLUSH with filt_k=cfg_k.
- cfg_k=0 is legal (depth 1): SETTLE_N=1+PIPE_LAT.
- Glitch-free: filt_enable and filt_reset are never high on the same cycle.

Test Plan:
- Defaults (K_DEPTH=25, PIPE_LAT=4, FLUSH_CYCLES=4), release reset_n, ch_en=1, sample_strobe=1 constantly -> filt_reset high 4 clocks after FLUSH entry. filt_enable then rises, and filt_valid rises with the 30th enable. state sequence 0,1,2,3.
- Same, with sample_strobe every 3rd clock -> exactly 30 enable pulses before filt_valid=1, about 90 clocks in SETTLE. filt_enable is never high without a strobe on the prior cycle.
- hold=1 for 10 strobes midway through SETTLE -> those 10 strobes produce no enable; filt_valid is delayed by exactly 10 strobes. Repeat hold in RUN -> filt_valid stays 1.
- In RUN, cfg_load with cfg_k=7 -> next clock filt_valid=0, filt_k=7, filt_reset=1 for 4 clocks. filt_valid returns after 12 enables.
- ch_en=0 mid-SETTLE -> next clock state=IDLE, filt_reset=1, filt_valid=0. Re-enable -> full flush/settle restarts with counters reloaded.
- reset_n pulsed low asynchronously mid-RUN, between clock edges -> all outputs take reset values before the next edge, filt_k=25. cfg_load in the same cycle as ch_en rising (cfg_k=0) -> FLUSH with filt_k=0; filt_valid after 5 enables.
